// File: rtl/riscat_pkg.sv
// Shared types and helpers for the issue/operand-fetch stage in front of the
// 32x32-bit register file.
package riscat_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0]     xlen_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  // Contents of the execute-stage pipeline register.
  typedef struct packed {
    xlen_t     op_a;
    xlen_t     op_b;
    reg_addr_t rd;
    logic      rd_we;
  } ex_pkt_t;

  // One-hot mask of a register address; x0 never appears in any mask
  // because it can never be busy.
  function automatic reg_mask_t addr_onehot(input logic en, input reg_addr_t addr);
    reg_mask_t m;
    m = {NUM_REGS{1'b0}};
    if (en && (addr != 5'd0)) begin
      m[addr] = 1'b1;
    end else begin
      m = {NUM_REGS{1'b0}};
    end
    return m;
  endfunction

  // Operand source selection: x0 or an unused source reads as zero, a
  // same-cycle writeback to the source wins over the register file.
  function automatic xlen_t select_operand(input logic      use_src,
                                           input reg_addr_t src,
                                           input logic      wb_en,
                                           input reg_addr_t wb_addr,
                                           input xlen_t     wb_data,
                                           input xlen_t     rf_data);
    xlen_t v;
    if (!use_src || (src == 5'd0)) begin
      v = 32'd0;
    end else if (wb_en && (wb_addr == src)) begin
      v = wb_data;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the operand-fetch
// stage. The stage itself uses the slave view; the surrounding pipeline (or a
// bench) uses the master view.
interface operand_fetch_if;
  import riscat_pkg::*;

  // decode handshake
  logic      id_valid;
  logic      id_ready;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  reg_addr_t id_rd;
  logic      id_use_rs1;
  logic      id_use_rs2;
  logic      id_rd_we;

  // register-file read ports
  logic      rf_rd0_en;
  reg_addr_t rf_rd0_addr;
  xlen_t     rf_rd0_data;
  logic      rf_rd1_en;
  reg_addr_t rf_rd1_addr;
  xlen_t     rf_rd1_data;

  // register-file write port
  logic      rf_wr_en;
  reg_addr_t rf_wr_addr;
  xlen_t     rf_wr_data;

  // writeback from downstream
  logic      wb_en;
  reg_addr_t wb_addr;
  xlen_t     wb_data;

  // execute handshake
  logic      ex_valid;
  logic      ex_ready;
  xlen_t     ex_op_a;
  xlen_t     ex_op_b;
  reg_addr_t ex_rd;
  logic      ex_rd_we;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_rd_we,
    output id_ready,
    output rf_rd0_en, rf_rd0_addr, rf_rd1_en, rf_rd1_addr,
    input  rf_rd0_data, rf_rd1_data,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    input  wb_en, wb_addr, wb_data,
    output ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_we,
    input  ex_ready
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_rd_we,
    input  id_ready,
    input  rf_rd0_en, rf_rd0_addr, rf_rd1_en, rf_rd1_addr,
    output rf_rd0_data, rf_rd1_data,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    output wb_en, wb_addr, wb_data,
    input  ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_we,
    output ex_ready
  );

endinterface

// File: rtl/operand_fetch_scoreboard32.sv
// Busy scoreboard for registers x1..x31. A set and a clear of the same
// register in one cycle leaves it busy: the new writer owns it.
module scoreboard32
  import riscat_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  output reg_mask_t busy
);

  reg_mask_t busy_q;
  reg_mask_t busy_d;
  reg_mask_t set_mask_s;
  reg_mask_t clr_mask_s;

  // Next busy state: clear first, then set so that set wins; bit 0 forced low.
  always_comb begin
    set_mask_s = addr_onehot(set_en, set_addr);
    clr_mask_s = addr_onehot(clr_en, clr_addr);
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue/operand-fetch stage: drives the register-file ports, bypasses
// same-cycle writeback data, stalls RAW/WAW hazards against the busy
// scoreboard and hands registered operands to execute over valid/ready.
module operand_fetch
  import riscat_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  operand_fetch_if.slave bus
);

  reg_mask_t busy_s;
  reg_mask_t eff_busy_s;
  logic      stall_s;
  logic      id_ready_s;
  logic      fire_s;
  xlen_t     op_a_s;
  xlen_t     op_b_s;

  ex_pkt_t   ex_pkt_q;
  ex_pkt_t   ex_pkt_d;
  logic      ex_valid_q;
  logic      ex_valid_d;

  scoreboard32 u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (fire_s & bus.id_rd_we),
    .set_addr (bus.id_rd),
    .clr_en   (bus.wb_en),
    .clr_addr (bus.wb_addr),
    .busy     (busy_s)
  );

  // Hazard detection: a register being written back this cycle is already
  // free, which lets its consumer issue in the same cycle as the writeback.
  always_comb begin
    eff_busy_s = busy_s & ~addr_onehot(bus.wb_en, bus.wb_addr);
    stall_s    = (bus.id_use_rs1 & eff_busy_s[bus.id_rs1])
               | (bus.id_use_rs2 & eff_busy_s[bus.id_rs2])
               | (bus.id_rd_we   & eff_busy_s[bus.id_rd]);
    id_ready_s = ~stall_s & (~ex_valid_q | bus.ex_ready);
    fire_s     = bus.id_valid & id_ready_s;
  end

  // Operand muxes: zero / writeback bypass / register-file data.
  always_comb begin
    op_a_s = select_operand(bus.id_use_rs1, bus.id_rs1, bus.wb_en, bus.wb_addr,
                            bus.wb_data, bus.rf_rd0_data);
    op_b_s = select_operand(bus.id_use_rs2, bus.id_rs2, bus.wb_en, bus.wb_addr,
                            bus.wb_data, bus.rf_rd1_data);
  end

  // Execute register next state: load on fire, drop valid once consumed,
  // otherwise hold everything stable.
  always_comb begin
    ex_pkt_d   = ex_pkt_q;
    ex_valid_d = ex_valid_q;
    if (fire_s) begin
      ex_valid_d     = 1'b1;
      ex_pkt_d.op_a  = op_a_s;
      ex_pkt_d.op_b  = op_b_s;
      ex_pkt_d.rd    = bus.id_rd;
      ex_pkt_d.rd_we = bus.id_rd_we & (bus.id_rd != 5'd0);
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // Execute pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_pkt_q   <= '{op_a: 32'd0, op_b: 32'd0, rd: 5'd0, rd_we: 1'b0};
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pkt_q   <= ex_pkt_d;
    end
  end

  // Register-file ports are straight combinational pass-through.
  assign bus.rf_rd0_en   = bus.id_valid & bus.id_use_rs1;
  assign bus.rf_rd0_addr = bus.id_rs1;
  assign bus.rf_rd1_en   = bus.id_valid & bus.id_use_rs2;
  assign bus.rf_rd1_addr = bus.id_rs2;
  assign bus.rf_wr_en    = bus.wb_en & (bus.wb_addr != 5'd0);
  assign bus.rf_wr_addr  = bus.wb_addr;
  assign bus.rf_wr_data  = bus.wb_data;

  assign bus.id_ready = id_ready_s;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op_a  = ex_pkt_q.op_a;
  assign bus.ex_op_b  = ex_pkt_q.op_b;
  assign bus.ex_rd    = ex_pkt_q.rd;
  assign bus.ex_rd_we = ex_pkt_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a small register-file model sits on the
// rf ports, each scenario task drives decode/writeback and checks inline.
module tb_operand_fetch;
  import riscat_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  operand_fetch_if bus();

  operand_fetch dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register-file model. x0 returns junk so that only the stage's own
  // zeroing can make an x0 operand read as zero.
  xlen_t rf_mem [NUM_REGS];
  always @(posedge clk) if (bus.rf_wr_en) rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
  assign bus.rf_rd0_data = (bus.rf_rd0_addr == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[bus.rf_rd0_addr];
  assign bus.rf_rd1_data = (bus.rf_rd1_addr == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[bus.rf_rd1_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                             input logic u1, input logic u2, input logic we);
    bus.id_valid = 1'b1;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_rd_we = we;
  endtask

  task automatic drive_wb(input logic en, input reg_addr_t addr, input xlen_t data);
    bus.wb_en = en; bus.wb_addr = addr; bus.wb_data = data;
  endtask

  task automatic drive_idle();
    drive_issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ex_ready = 1'b1;
    drive_idle();
    drive_wb(1'b0, 5'd0, 32'd0);
    #2;
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); end
    n_checks++; if (bus.ex_op_a !== 32'd0) begin n_fail++; $display("FAIL reset_op_a: got %h want 0", bus.ex_op_a); end
    n_checks++; if (bus.ex_op_b !== 32'd0) begin n_fail++; $display("FAIL reset_op_b: got %h want 0", bus.ex_op_b); end
    n_checks++; if (bus.ex_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", bus.ex_rd); end
    n_checks++; if (bus.ex_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd_we: got %b want 0", bus.ex_rd_we); end
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready: got %b want 1", bus.id_ready); end
    drive_issue(5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    drive_wb(1'b1, 5'd0, 32'h1234);
    #1;
    n_checks++; if ({bus.rf_rd0_en, bus.rf_rd0_addr} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL reset_rd0_port: got %b/%0d want 1/3", bus.rf_rd0_en, bus.rf_rd0_addr); end
    n_checks++; if ({bus.rf_rd1_en, bus.rf_rd1_addr} !== {1'b0, 5'd4}) begin n_fail++; $display("FAIL reset_rd1_port: got %b/%0d want 0/4", bus.rf_rd1_en, bus.rf_rd1_addr); end
    n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_x0: got %b want 0", bus.rf_wr_en); end
    drive_idle();
    drive_wb(1'b0, 5'd0, 32'd0);
    tick(); tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_preload();
    drive_wb(1'b1, 5'd3, 32'h11);
    #1;
    n_checks++; if ({bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data} !== {1'b1, 5'd3, 32'h11}) begin n_fail++; $display("FAIL preload_wr_port: got %b/%0d/%h want 1/3/11", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data); end
    tick();
    drive_wb(1'b1, 5'd4, 32'h22); tick();
    drive_wb(1'b1, 5'd6, 32'h66); tick();
    drive_wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_basic_issue();
    drive_issue(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL basic_id_ready: got %b want 1", bus.id_ready); end
    tick();
    drive_idle();
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ex_valid: got %b want 1", bus.ex_valid); end
    n_checks++; if (bus.ex_op_a !== 32'h11) begin n_fail++; $display("FAIL basic_op_a: got %h want 11", bus.ex_op_a); end
    n_checks++; if (bus.ex_op_b !== 32'h22) begin n_fail++; $display("FAIL basic_op_b: got %h want 22", bus.ex_op_b); end
    n_checks++; if ({bus.ex_rd, bus.ex_rd_we} !== {5'd5, 1'b1}) begin n_fail++; $display("FAIL basic_rd: got %0d/%b want 5/1", bus.ex_rd, bus.ex_rd_we); end
  endtask

  task automatic test_raw_bypass();
    drive_issue(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b want 0", bus.id_ready); end
    drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", bus.id_ready); end
    n_checks++; if (bus.rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL raw_wr_en: got %b want 1", bus.rf_wr_en); end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    n_checks++; if (bus.ex_op_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_op_a: got %h want deadbeef", bus.ex_op_a); end
    n_checks++; if (bus.ex_rd_we !== 1'b0) begin n_fail++; $display("FAIL bypass_rd_we: got %b want 0", bus.ex_rd_we); end
    // x5 is free again and the register file now holds the written value
    drive_issue(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL busy5_cleared: got %b want 1", bus.id_ready); end
    tick();
    n_checks++; if ({bus.ex_op_a, bus.ex_op_b} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rf_after_wb: got %h/%h want deadbeef/deadbeef", bus.ex_op_a, bus.ex_op_b); end
    // write-after-write on x5 stalls until its writeback arrives
    drive_issue(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b want 0", bus.id_ready); end
    drive_wb(1'b1, 5'd5, 32'h55);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %b want 1", bus.id_ready); end
    tick();
    drive_idle();
    drive_wb(1'b1, 5'd5, 32'h55);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_x0();
    drive_issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL x0_write_ready: got %b want 1", bus.id_ready); end
    tick();
    n_checks++; if ({bus.ex_rd, bus.ex_rd_we} !== {5'd0, 1'b0}) begin n_fail++; $display("FAIL x0_rd_we: got %0d/%b want 0/0", bus.ex_rd, bus.ex_rd_we); end
    drive_issue(5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
    drive_wb(1'b1, 5'd0, 32'hFFFF);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall: got %b want 1", bus.id_ready); end
    n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %b want 0", bus.rf_wr_en); end
    tick();
    drive_idle();
    drive_wb(1'b0, 5'd0, 32'd0);
    n_checks++; if (bus.ex_op_a !== 32'd0) begin n_fail++; $display("FAIL x0_op_a: got %h want 0", bus.ex_op_a); end
    n_checks++; if (bus.ex_op_b !== 32'd0) begin n_fail++; $display("FAIL unused_op_b: got %h want 0", bus.ex_op_b); end
  endtask

  task automatic test_backpressure();
    drive_issue(5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b1);
    tick();
    bus.ex_ready = 1'b0;
    drive_issue(5'd4, 5'd3, 5'd11, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL bp_id_ready[%0d]: got %b want 0", i, bus.id_ready); end
      n_checks++; if ({bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd} !== {1'b1, 32'h11, 32'h22, 5'd10}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h/%h/%0d want 1/11/22/10", i, bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd);
      end
      tick();
    end
    bus.ex_ready = 1'b1;
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", bus.id_ready); end
    tick();
    drive_idle();
    n_checks++; if ({bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd} !== {1'b1, 32'h22, 32'h11, 5'd11}) begin
      n_fail++; $display("FAIL bp_next: got %b/%h/%h/%0d want 1/22/11/11", bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd);
    end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.ex_valid); end
  endtask

  task automatic test_back_to_back();
    reg_addr_t rs1_t [3] = '{5'd3, 5'd4, 5'd6};
    reg_addr_t rs2_t [3] = '{5'd6, 5'd3, 5'd4};
    xlen_t     a_t   [3] = '{32'h11, 32'h22, 32'h66};
    xlen_t     b_t   [3] = '{32'h66, 32'h11, 32'h22};
    for (int i = 0; i < 3; i++) begin
      drive_issue(rs1_t[i], rs2_t[i], 5'(12 + i), 1'b1, 1'b1, 1'b1);
      #1;
      n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.id_ready); end
      tick();
      n_checks++; if ({bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd} !== {1'b1, a_t[i], b_t[i], 5'(12 + i)}) begin
        n_fail++; $display("FAIL b2b_out[%0d]: got %b/%h/%h/%0d want 1/%h/%h/%0d", i, bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_rd, a_t[i], b_t[i], 12 + i);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_set_wins();
    drive_issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
    tick();
    drive_issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
    drive_wb(1'b1, 5'd7, 32'h77);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL setwins_accept: got %b want 1", bus.id_ready); end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_issue(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL setwins_busy7: got %b want 0", bus.id_ready); end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive_issue(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", bus.ex_valid); end
    bus.ex_ready = 1'b0;
    drive_issue(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_stall: got %b want 0", bus.id_ready); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({bus.ex_valid, bus.ex_rd, bus.ex_rd_we} !== {1'b0, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_async_ex: got %b/%0d/%b want 0/0/0", bus.ex_valid, bus.ex_rd, bus.ex_rd_we);
    end
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_busy9: got %b want 1", bus.id_ready); end
    bus.ex_ready = 1'b1;
    drive_idle();
    tick();
    #2 reset_n = 1'b1;
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dropped: got %b want 0", bus.ex_valid); end
    drive_wb(1'b1, 5'd9, 32'hCAFE);
    #1;
    n_checks++; if (bus.rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL rst_wb_wr_en: got %b want 1", bus.rf_wr_en); end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_issue(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wb_busy9: got %b want 1", bus.id_ready); end
    tick();
    drive_idle();
    n_checks++; if ({bus.ex_op_a, bus.ex_rd_we} !== {32'hCAFE, 1'b1}) begin n_fail++; $display("FAIL rst_wb_op_a: got %h/%b want cafe/1", bus.ex_op_a, bus.ex_rd_we); end
    tick();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_issue();
    test_raw_bypass();
    test_x0();
    test_backpressure();
    test_back_to_back();
    test_set_wins();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
